// File: rtl/fifo_rd_stream_pkg.sv
// ============================================================================
// Module   : fifo_rd_stream_pkg
// Brief    : Shared types and sizes for the FIFO read-side stream adapter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_rd_stream_pkg;

   localparam int BUF_DEPTH = 2;
   localparam int OCC_WIDTH = 2;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/stream_buf2.sv
// ============================================================================
// Module   : stream_buf2
// Brief    : Two-entry register FIFO with push/pop/clear, occupancy and head.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_buf2
   import fifo_rd_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_push,
   input  logic                  i_pop,
   input  logic                  i_clear,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic [OCC_WIDTH-1:0]  o_occ,
   output logic [DATA_WIDTH-1:0] o_head
);

   logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
   logic                  r_rd_ptr;
   logic                  r_wr_ptr;
   logic [OCC_WIDTH-1:0]  r_occ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_occ    <= '0;
      end else if (i_clear) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_occ    <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (i_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         // Push and pop together keep the count and just rotate both pointers.
         case ({i_push, i_pop})
            2'b10:   r_occ <= r_occ + OCC_WIDTH'(1);
            2'b01:   r_occ <= r_occ - OCC_WIDTH'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign o_occ  = r_occ;
   assign o_head = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/fifo_rd_stream.sv
// ============================================================================
// Module   : fifo_rd_stream
// Brief    : Pops the async FIFO read port into a valid/ready stream with flush.
//            Optional pop counter output enabled by FIFO_RD_STREAM_WORD_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_stream
   import fifo_rd_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst_n,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   input  logic                  flush,
   output logic                  flush_busy
`ifdef FIFO_RD_STREAM_WORD_CNT_EN
   ,
   output logic [31:0]           word_cnt
`endif
);

   localparam logic [OCC_WIDTH:0] c_buf_depth = BUF_DEPTH[OCC_WIDTH:0];

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_inflight;
   logic                  r_started;
   logic [OCC_WIDTH-1:0]  w_occ;
   logic [OCC_WIDTH:0]    w_level;
   logic [DATA_WIDTH-1:0] w_head;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_clear;

   stream_buf2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .clk     (rd_clk),
      .rst_n   (rd_rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_clear (w_clear),
      .i_data  (fifo_rd_data),
      .o_occ   (w_occ),
      .o_head  (w_head)
   );

   assign m_valid    = (r_state == RUN) && (w_occ != '0);
   assign m_data     = w_head;
   assign w_pop      = m_valid & m_ready;
   assign flush_busy = (r_state == DRAIN);

   // Entries committed after this edge: buffered + arriving - leaving.
   assign w_level = {1'b0, w_occ} + {{OCC_WIDTH{1'b0}}, r_inflight}
                  - {{OCC_WIDTH{1'b0}}, w_pop};

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         r_state    <= RUN;
         r_inflight <= 1'b0;
         r_started  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= fifo_rd_en;
         r_started  <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      fifo_rd_en  = 1'b0;
      w_push      = 1'b0;
      w_clear     = 1'b0;
      case (r_state)
         RUN: begin
            if (flush) begin
               w_state_nxt = DRAIN;
               w_clear     = 1'b1;
            end else begin
               w_push     = r_inflight;
               fifo_rd_en = r_started & ~fifo_empty & (w_level < c_buf_depth);
            end
         end
         DRAIN: begin
            // Words popped here are dropped; leave only once nothing is in flight.
            fifo_rd_en = ~fifo_empty;
            if (!flush && fifo_empty && !r_inflight) begin
               w_state_nxt = RUN;
            end
         end
         default: w_state_nxt = RUN;
      endcase
   end

`ifdef FIFO_RD_STREAM_WORD_CNT_EN
   logic [31:0] r_word_cnt;

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         r_word_cnt <= '0;
      end else if (w_pop) begin
         r_word_cnt <= r_word_cnt + 32'd1;
      end
   end

   assign word_cnt = r_word_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
// ============================================================================
// Module   : tb_fifo_rd_stream
// Brief    : Self-checking bench with a queue-based FIFO and stream model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_stream;

   localparam int DW = 8;

   logic          clk;
   logic          rd_rst_n;
   logic          fifo_empty;
   logic [DW-1:0] fifo_rd_data;
   logic          fifo_rd_en;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_ready;
   logic          flush;
   logic          flush_busy;
`ifdef FIFO_RD_STREAM_WORD_CNT_EN
   logic [31:0]   word_cnt;
`endif

   fifo_rd_stream #(
      .DATA_WIDTH (DW)
   ) dut (
      .rd_clk       (clk),
      .rd_rst_n     (rd_rst_n),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_en   (fifo_rd_en),
      .m_valid      (m_valid),
      .m_data       (m_data),
      .m_ready      (m_ready),
      .flush        (flush),
      .flush_busy   (flush_busy)
`ifdef FIFO_RD_STREAM_WORD_CNT_EN
      ,
      .word_cnt     (word_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            checks   = 0;
   int            failures = 0;

   logic [DW-1:0] src_q[$];
   logic [DW-1:0] sent_q[$];
   logic [DW-1:0] avail_q[$];
   logic [DW-1:0] out_log[$];
   int            pop_cyc[$];
   bit            drain     = 1'b0;
   bit            infl      = 1'b0;
   logic [DW-1:0] infl_word = '0;
   int            pops      = 0;
   int            rd_pulses = 0;
   int            cyc       = 0;
   bit            after_rst = 1'b1;
   bit            rdy_cfg   = 1'b0;
   bit            flush_cfg = 1'b0;
   bit            hide_cfg  = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic upd_empty();
      fifo_empty = (src_q.size() == 0) || hide_cfg;
   endtask

   task automatic load(input logic [DW-1:0] w);
      src_q.push_back(w);
      sent_q.push_back(w);
      upd_empty();
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         m_ready = rdy_cfg;
         flush   = flush_cfg;
         upd_empty();
      end
   endtask

   // FIFO read port: data appears the cycle after a pop.
   always @(posedge clk) begin
      #1;
      fifo_rd_data = infl ? infl_word : DW'($urandom);
   end

   // Reference model and per-cycle comparison.
   always @(negedge clk) begin
      bit            exp_v;
      bit            exp_pop;
      bit            exp_rd;
      bit            rd;
      logic [DW-1:0] w;
      cyc++;
      if (!rd_rst_n) begin
         chk("rst_rd_en", fifo_rd_en, 0);
         chk("rst_m_valid", m_valid, 0);
         chk("rst_m_data", m_data, 0);
         chk("rst_flush_busy", flush_busy, 0);
         avail_q.delete();
         drain     = 1'b0;
         infl      = 1'b0;
         pops      = 0;
         after_rst = 1'b1;
      end else begin
         exp_v   = !drain && (avail_q.size() != 0);
         exp_pop = exp_v && m_ready;
         if (drain)
            exp_rd = !fifo_empty;
         else
            exp_rd = !fifo_empty && !flush
                     && (avail_q.size() + int'(infl) - int'(exp_pop) < 2);
         chk("m_valid", m_valid, exp_v);
         if (exp_v) chk("m_data", m_data, avail_q[0]);
         chk("flush_busy", flush_busy, drain);
         chk("no_underflow", fifo_rd_en & fifo_empty, 0);
         if (!after_rst) chk("fifo_rd_en", fifo_rd_en, exp_rd);
`ifdef FIFO_RD_STREAM_WORD_CNT_EN
         chk("word_cnt", word_cnt, pops);
`endif
         rd = fifo_rd_en && !fifo_empty;
         w  = '0;
         if (rd) begin
            w = src_q.pop_front();
            rd_pulses++;
         end
         if (exp_pop) begin
            void'(avail_q.pop_front());
            pops++;
            out_log.push_back(m_data);
            pop_cyc.push_back(cyc);
         end
         if (!drain && flush) begin
            avail_q.delete();
            drain = 1'b1;
         end else if (!drain && infl) begin
            avail_q.push_back(infl_word);
         end else if (drain && !flush && fifo_empty && !infl) begin
            drain = 1'b0;
         end
         infl = rd;
         if (rd) infl_word = w;
         after_rst = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int lim;
      rd_rst_n = 1'b1;
      m_ready  = 1'b1;
      flush    = 1'b0;
      rdy_cfg  = 1'b1;
      for (int i = 1; i <= 8; i++) load(DW'(i));
      #2 rd_rst_n = 1'b0;

      // Reset held with data available, then streaming at full rate.
      step(3);
      rd_rst_n  = 1'b1;
      rd_pulses = 0;
      out_log.delete();
      pop_cyc.delete();
      step(16);
      chk("stream_count", out_log.size(), 8);
      for (int i = 0; i < out_log.size() && i < 8; i++) chk("stream_data", out_log[i], i + 1);
      if (pop_cyc.size() == 8) chk("stream_no_bubble", pop_cyc[7] - pop_cyc[0], 7);
      chk("stream_rd_pulses", rd_pulses, 8);

      // Backpressure.
      rdy_cfg = 1'b0;
      step(1);
      rd_pulses = 0;
      out_log.delete();
      for (int i = 1; i <= 5; i++) load(DW'(i));
      step(8);
      chk("bp_rd_pulses", rd_pulses, 2);
      chk("bp_m_valid", m_valid, 1);
      chk("bp_m_data", m_data, 8'h01);
      rdy_cfg = 1'b1;
      step(10);
      chk("bp_count", out_log.size(), 5);
      for (int i = 0; i < out_log.size() && i < 5; i++) chk("bp_data", out_log[i], i + 1);

      // Flush: two buffered words plus six still in the FIFO.
      rdy_cfg = 1'b0;
      step(1);
      for (int i = 0; i < 8; i++) load(8'h11 + DW'(i));
      step(8);
      out_log.delete();
      rd_pulses = 0;
      flush_cfg = 1'b1;
      step(1);
      flush_cfg = 1'b0;
      step(1);
      chk("flush_m_valid", m_valid, 0);
      chk("flush_busy_set", flush_busy, 1);
      lim = 0;
      while (flush_busy && lim < 30) begin
         step(1);
         lim++;
      end
      chk("drain_timeout", flush_busy, 0);
      chk("drain_rd_pulses", rd_pulses, 6);
      chk("drain_no_output", out_log.size(), 0);
      rdy_cfg = 1'b1;
      step(1);
      load(8'hAA);
      lim = 0;
      while (out_log.size() == 0 && lim < 10) begin
         step(1);
         lim++;
      end
      chk("post_flush_count", out_log.size(), 1);
      if (out_log.size() > 0) chk("post_flush_data", out_log[0], 8'hAA);
`ifdef FIFO_RD_STREAM_WORD_CNT_EN
      chk("word_cnt_total", word_cnt, 14);
`endif

      // Randomized underflow guard and ordering.
      step(2);
      sent_q.delete();
      out_log.delete();
      for (int i = 0; i < 1000; i++) begin
         rdy_cfg  = 1'($urandom_range(0, 1));
         hide_cfg = ($urandom_range(0, 3) == 0);
         step(1);
         if ($urandom_range(0, 2) != 0) load(DW'($urandom));
      end
      rdy_cfg  = 1'b1;
      hide_cfg = 1'b0;
      lim = 0;
      while (out_log.size() < sent_q.size() && lim < 1500) begin
         step(1);
         lim++;
      end
      step(3);
      chk("rand_count", out_log.size(), sent_q.size());
      bad = 0;
      for (int i = 0; i < out_log.size() && i < sent_q.size(); i++)
         if (out_log[i] !== sent_q[i]) bad++;
      chk("rand_order", bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
